// File: rtl/avalon_st_pkt_arbiter.sv
// Packet-locked round-robin arbiter: NUM_SRC Avalon-ST sources share one registered sink stage.
// Define AVALON_ARB_PRIO0_EN to give source 0 absolute priority at every idle arbitration.
module avalon_st_pkt_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 64,
  parameter int EMPTY_W = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_SRC-1:0]           src_valid,
  output logic [NUM_SRC-1:0]           src_ready,
  input  logic [NUM_SRC-1:0]           src_startofpacket,
  input  logic [NUM_SRC-1:0]           src_endofpacket,
  input  logic [NUM_SRC*DATA_W-1:0]    src_data,
  input  logic [NUM_SRC*EMPTY_W-1:0]   src_empty,
  output logic                         snk_valid,
  input  logic                         snk_ready,
  output logic                         snk_startofpacket,
  output logic                         snk_endofpacket,
  output logic [DATA_W-1:0]            snk_data,
  output logic [EMPTY_W-1:0]           snk_empty,
  output logic [$clog2(NUM_SRC)-1:0]   grant_id,
  output logic                         busy,
  output logic                         sop_err
);

  localparam int GW = $clog2(NUM_SRC);

  typedef enum logic {IDLE, PKT} state_t;

  state_t              state;
  logic [GW-1:0]       rr_ptr;
  logic                first_beat;
  logic [NUM_SRC-1:0]  req;
  logic                any_req;
  logic [GW-1:0]       pick;
  logic                take_ready;
  logic                accept;
  logic                g_valid;
  logic                g_sop;
  logic                g_eop;
  logic [DATA_W-1:0]   g_data;
  logic [EMPTY_W-1:0]  g_empty;

  assign req        = src_valid & src_startofpacket;
  assign take_ready = !snk_valid || snk_ready;

  assign g_valid = src_valid[grant_id];
  assign g_sop   = src_startofpacket[grant_id];
  assign g_eop   = src_endofpacket[grant_id];
  assign g_data  = src_data[int'(grant_id)*DATA_W +: DATA_W];
  assign g_empty = src_empty[int'(grant_id)*EMPTY_W +: EMPTY_W];
  assign accept  = (state == PKT) && g_valid && take_ready;

  // First requester after rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    pick    = '0;
    any_req = 1'b0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_SRC;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        pick    = GW'(idx);
      end
    end
`ifdef AVALON_ARB_PRIO0_EN
    if (req[0]) begin
      any_req = 1'b1;
      pick    = '0;
    end
`endif
  end

  always_comb begin
    src_ready = '0;
    if (state == PKT) src_ready[grant_id] = take_ready;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      rr_ptr            <= GW'(NUM_SRC - 1);
      first_beat        <= 1'b0;
      grant_id          <= '0;
      busy              <= 1'b0;
      sop_err           <= 1'b0;
      snk_valid         <= 1'b0;
      snk_startofpacket <= 1'b0;
      snk_endofpacket   <= 1'b0;
      snk_data          <= '0;
      snk_empty         <= '0;
    end else begin
      sop_err <= 1'b0;

      if (accept) begin
        snk_valid         <= 1'b1;
        snk_startofpacket <= g_sop;
        snk_endofpacket   <= g_eop;
        snk_data          <= g_data;
        snk_empty         <= g_empty;
        sop_err           <= g_sop && !first_beat;
        first_beat        <= 1'b0;
      end else if (snk_ready) begin
        snk_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= PKT;
            busy       <= 1'b1;
            grant_id   <= pick;
            first_beat <= 1'b1;
`ifdef AVALON_ARB_PRIO0_EN
            if (!req[0]) rr_ptr <= pick;
`else
            rr_ptr <= pick;
`endif
          end
        end
        PKT: begin
          if (accept && g_eop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
